// File: rtl/sincos_linear_nco.sv
// Dual sine/cosine generator fed by an external phase stream or an internal NCO.
// Quarter-wave table (4096 points) plus linear interpolation, three-stage ready/valid pipeline.
module sincos_linear_nco #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int TAG_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mode_i,
  input  logic [31:0]             phase_i,
  input  logic [31:0]             freq_i,
  input  logic [31:0]             offset_i,
  input  logic                    sync_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [OUTPUT_WIDTH-1:0] sin_o,
  output logic [OUTPUT_WIDTH-1:0] cos_o,
  output logic [TAG_WIDTH-1:0]    tag_o,
  output logic                    valid_o,
  input  logic                    ready_i
);
  localparam int W      = OUTPUT_WIDTH;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [127:0] PI_Q60 = 128'h3243_F6A8_885A_308D;

  // Table point idx = sin(idx*pi/8192) scaled by 2^34, raised by h^2/16 so the chord
  // error is centred around zero instead of always sitting below the curve.
  function automatic logic [35:0] calc_y0(input int idx);
    logic [127:0] x, x2, term, sum, h, bias;
    x    = (128'(idx) * PI_Q60) >> 13;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    h    = PI_Q60 >> 13;
    bias = ((h * h) >> 60) >> 4;
    sum  = sum + ((sum * bias) >> 60);
    calc_y0 = 36'((sum + (128'd1 << 25)) >> 26);
  endfunction

  function automatic logic [17:0] calc_dy(input logic [35:0] y_lo, input logic [35:0] y_hi);
    logic [35:0] diff;
    diff    = y_hi - y_lo + 36'd32;
    calc_dy = diff[23:6];
  endfunction

  logic [35:0] rom_y36  [DEPTH];
  logic [17:0] rom_dy18 [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [35:0] Y_LO = calc_y0(gi);
    localparam logic [35:0] Y_HI = calc_y0(gi + 1);
    assign rom_y36[gi]  = Y_LO;
    assign rom_dy18[gi] = calc_dy(Y_LO, Y_HI);
  end

  logic                 advance;
  logic                 issue;
  logic [31:0]          phase_sel;
  logic [31:0]          acc_q, acc_d;
  logic                 s0_valid_q, s1_valid_q, out_valid_q;
  logic [TAG_WIDTH-1:0] s0_tag_q, s1_tag_q, tag_q;
  logic [W-1:0]         sin_q, cos_q;
  logic [W-1:0]         res [2];

  assign advance   = ~out_valid_q | ready_i;
  assign issue     = advance & (mode_i | valid_i);
  assign phase_sel = mode_i ? (acc_q + offset_i) : phase_i;

  always_comb begin
    acc_d = acc_q;
    if (sync_i)                acc_d = '0;
    else if (issue && mode_i)  acc_d = acc_q + freq_i;
  end

  // Channel 0 is sine, channel 1 is cosine (phase advanced by a quarter turn).
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [31:0]       ph;
    logic [1:0]        s0_quad_q, s1_quad_q;
    logic [ADDR_W-1:0] s0_addr_q;
    logic [17:0]       s0_frac_q, s1_frac_q;
    logic [35:0]       s1_y0_q;
    logic [17:0]       s1_dy_q;
    logic [35:0]       prod;
    logic [47:0]       z;
    logic [W-1:0]      r;

    assign ph = phase_sel + (32'(gi) << 30);

    always_ff @(posedge clk) begin
      if (advance) begin
        s0_quad_q <= ph[31:30];
        s0_addr_q <= ph[30] ? ~ph[29:18] : ph[29:18];
        s0_frac_q <= ph[30] ? ~ph[17:0] : ph[17:0];
        s1_quad_q <= s0_quad_q;
        s1_frac_q <= s0_frac_q;
        s1_y0_q   <= rom_y36[s0_addr_q];
        s1_dy_q   <= rom_dy18[s0_addr_q];
      end
    end

    assign prod    = s1_dy_q * s1_frac_q;
    assign z       = {s1_y0_q, 12'd0} + {12'd0, prod};
    assign r       = W'(z >> (48 - W));
    assign res[gi] = s1_quad_q[1] ? ~r : r;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s0_tag_q <= tag_i;
      s1_tag_q <= s0_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q       <= '0;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
      tag_q       <= '0;
    end else begin
      acc_q <= acc_d;
      if (advance) begin
        s0_valid_q  <= issue;
        s1_valid_q  <= s0_valid_q;
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sin_q <= res[0];
          cos_q <= res[1];
          tag_q <= s1_tag_q;
        end
      end
    end
  end

  assign ready_o = advance;
  assign sin_o   = sin_q;
  assign cos_o   = cos_q;
  assign tag_o   = tag_q;
  assign valid_o = out_valid_q;

endmodule

// File: tb/tb_sincos_linear_nco.sv
// Bench for sincos_linear_nco: three widths side by side against a queue-style
// pipeline model and double-precision sin/cos.
module tb_sincos_linear_nco;
  localparam real TWO_PI = 6.283185307179586;
  localparam real TWO_32 = 4294967296.0;
  localparam real TWO_30 = 1073741824.0;
  localparam real TOL    = 24.0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mode_i;
  logic [31:0] phase_i, freq_i, offset_i;
  logic        sync_i;
  logic [7:0]  tag_i;
  logic        valid_i;
  logic        ready_i;

  logic        ready16, ready32, ready48;
  logic        valid16, valid32, valid48;
  logic [7:0]  tag16, tag32, tag48;
  logic [15:0] sin16, cos16;
  logic [31:0] sin32, cos32;
  logic [47:0] sin48, cos48;

  int errors = 0;
  int checks = 0;

  // Reference pipeline: slot 2 is the output register.
  logic        m_v   [3];
  logic [31:0] m_ph  [3];
  logic [7:0]  m_tag [3];
  logic [31:0] m_acc;

  always #5 clk = ~clk;

  sincos_linear_nco #(.OUTPUT_WIDTH(16), .TAG_WIDTH(8)) u_w16 (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .phase_i(phase_i), .freq_i(freq_i),
    .offset_i(offset_i), .sync_i(sync_i), .tag_i(tag_i), .valid_i(valid_i),
    .ready_o(ready16), .sin_o(sin16), .cos_o(cos16), .tag_o(tag16), .valid_o(valid16),
    .ready_i(ready_i));

  sincos_linear_nco #(.OUTPUT_WIDTH(32), .TAG_WIDTH(8)) u_w32 (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .phase_i(phase_i), .freq_i(freq_i),
    .offset_i(offset_i), .sync_i(sync_i), .tag_i(tag_i), .valid_i(valid_i),
    .ready_o(ready32), .sin_o(sin32), .cos_o(cos32), .tag_o(tag32), .valid_o(valid32),
    .ready_i(ready_i));

  sincos_linear_nco #(.OUTPUT_WIDTH(48), .TAG_WIDTH(8)) u_w48 (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .phase_i(phase_i), .freq_i(freq_i),
    .offset_i(offset_i), .sync_i(sync_i), .tag_i(tag_i), .valid_i(valid_i),
    .ready_o(ready48), .sin_o(sin48), .cos_o(cos48), .tag_o(tag48), .valid_o(valid48),
    .ready_i(ready_i));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
    end
  endtask

  task automatic chk_near(input string name, input logic [31:0] obs, input real ref_val);
    real e;
    checks++;
    e = real'($signed(obs)) - ref_val;
    assert (e <= TOL && e >= -TOL) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %0.1f (+-24)", name, obs, ref_val);
    end
  endtask

  // One clock: check ready_o, clock the model alongside the DUTs, check outputs.
  task automatic cycle();
    logic        adv, iss;
    logic [31:0] ph;
    real         sref, cref;
    #1;
    adv = !m_v[2] || ready_i;
    iss = adv && (mode_i || valid_i);
    ph  = mode_i ? (m_acc + offset_i) : phase_i;
    if (resetn) begin
      chk("ready_o_w32", 64'(ready32), 64'(adv));
      chk("ready_o_w16", 64'(ready16), 64'(adv));
      chk("ready_o_w48", 64'(ready48), 64'(adv));
    end
    @(posedge clk);
    if (!resetn) begin
      for (int s = 0; s < 3; s++) m_v[s] = 1'b0;
      m_acc = '0;
    end else begin
      if (adv) begin
        for (int s = 2; s > 0; s--) begin
          m_v[s]   = m_v[s-1];
          m_ph[s]  = m_ph[s-1];
          m_tag[s] = m_tag[s-1];
        end
        m_v[0]   = iss;
        m_ph[0]  = ph;
        m_tag[0] = tag_i;
      end
      if (sync_i)              m_acc = '0;
      else if (iss && mode_i)  m_acc = m_acc + freq_i;
    end
    #1;
    chk("valid_o_w32", 64'(valid32), 64'(m_v[2]));
    chk("valid_o_w16", 64'(valid16), 64'(m_v[2]));
    chk("valid_o_w48", 64'(valid48), 64'(m_v[2]));
    if (m_v[2]) begin
      sref = $sin(TWO_PI * real'(m_ph[2]) / TWO_32) * TWO_30;
      cref = $cos(TWO_PI * real'(m_ph[2]) / TWO_32) * TWO_30;
      chk("tag_o_w32", 64'(tag32), 64'(m_tag[2]));
      chk("tag_o_w16", 64'(tag16), 64'(m_tag[2]));
      chk("tag_o_w48", 64'(tag48), 64'(m_tag[2]));
      chk_near("sin_w32", sin32, sref);
      chk_near("cos_w32", cos32, cref);
      chk("sin_w16_vs_w48", 64'(sin16), 64'(sin48[47:32]));
      chk("cos_w16_vs_w48", 64'(cos16), 64'(cos48[47:32]));
      chk("sin_w32_vs_w48", 64'(sin32), 64'(sin48[47:16]));
      chk("cos_w32_vs_w48", 64'(cos32), 64'(cos48[47:16]));
      $display("out tag=%02h phase=%08h sin=%08h cos=%08h", tag32, m_ph[2], sin32, cos32);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_valid_o", 64'(valid32), 64'd0);
    chk("rst_sin_o", 64'(sin48), 64'd0);
    chk("rst_cos_o", 64'(cos48), 64'd0);
    chk("rst_tag_o", 64'(tag32), 64'd0);
    chk("rst_ready_o", 64'(ready32), 64'd1);
  endtask

  initial begin
    int w1, w2;
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 1'b0; m_ph[s] = '0; m_tag[s] = '0;
    end
    m_acc = '0;
    resetn = 1'b0; mode_i = 1'b0; phase_i = '0; freq_i = '0; offset_i = '0;
    sync_i = 1'b0; tag_i = '0; valid_i = 1'b0; ready_i = 1'b0;

    // Reset state (ready_i low so ready_o must come from the empty output stage).
    cycle();
    cycle();
    chk_reset_state();
    resetn = 1'b1;
    ready_i = 1'b1;

    // External phases at the four quadrant boundaries.
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; phase_i = 32'(i) << 30; tag_i = 8'(i);
      cycle();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Random external phases with random valid and backpressure.
    for (int i = 0; i < 60; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      phase_i = $urandom;
      tag_i   = 8'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    ready_i = 1'b1; valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // NCO ramp: clear acc without issuing, then 512 samples of 2^24 steps.
    sync_i = 1'b1; cycle(); sync_i = 1'b0;
    mode_i = 1'b1; freq_i = 32'h0100_0000; offset_i = '0;
    for (int k = 0; k < 512; k++) begin
      tag_i = 8'(k);
      cycle();
    end
    mode_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Backpressure: two 5-cycle stalls at random points in an NCO stream.
    mode_i = 1'b1; freq_i = $urandom; offset_i = $urandom;
    w1 = $urandom_range(10, 30);
    w2 = $urandom_range(45, 70);
    for (int i = 0; i < 80; i++) begin
      ready_i = !((i >= w1 && i < w1 + 5) || (i >= w2 && i < w2 + 5));
      tag_i   = 8'(i);
      cycle();
    end
    ready_i = 1'b1; mode_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Sync mid-stream: sample 5 uses the old acc, sample 6 starts from offset only.
    sync_i = 1'b1; cycle(); sync_i = 1'b0;
    mode_i = 1'b1; freq_i = 32'h1000_0000; offset_i = '0;
    for (int i = 0; i < 12; i++) begin
      tag_i    = 8'(i);
      sync_i   = (i == 5);
      offset_i = (i >= 5) ? 32'h2000_0000 : 32'h0;
      cycle();
      if (i == 8) begin
        chk("sync_sample6_tag", 64'(tag32), 64'd6);
        chk_near("sync_sample6_sin", sin32, 759250124.99);
      end
    end
    sync_i = 1'b0; mode_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Random mix of modes, sync, offsets and backpressure.
    for (int i = 0; i < 300; i++) begin
      mode_i   = $urandom_range(0, 1) == 1;
      valid_i  = $urandom_range(0, 1) == 1;
      phase_i  = $urandom;
      freq_i   = $urandom;
      offset_i = $urandom;
      sync_i   = ($urandom_range(0, 15) == 0);
      tag_i    = 8'($urandom);
      ready_i  = ($urandom_range(0, 4) != 0);
      cycle();
    end
    sync_i = 1'b0;

    // Reset with a full, stalled pipeline.
    mode_i = 1'b1; ready_i = 1'b1; freq_i = 32'h0300_0000;
    for (int i = 0; i < 4; i++) begin tag_i = 8'(8'hA0 + i); cycle(); end
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    resetn = 1'b0;
    cycle();
    chk_reset_state();
    resetn = 1'b1; mode_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; phase_i = (32'(i) << 30) + 32'h1555_5555; tag_i = 8'(i + 16);
      cycle();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
